// File: rtl/spif_responder_pkg.sv
// Shared definitions for the SPI-flash responder: opcodes, FSM states and
// the helper that maps an outgoing byte onto the qdo lines.
package spif_responder_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FREAD = 8'h0B;
  localparam logic [7:0] CMD_QREAD = 8'h6B;
  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;
  localparam logic [7:0] CMD_PP    = 8'h02;

  localparam int unsigned DUMMY_BITS = 8;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StDataOut,
    StIdOut,
    StStatOut,
    StDataIn,
    StIgnore
  } state_e;

  // Top bits of b as they appear on the pins: a nibble in quad mode,
  // otherwise a single bit on qdo[1].
  function automatic logic [3:0] out_lines(input logic quad, input logic [7:0] b);
    return quad ? b[7:4] : {2'b00, b[7], 1'b0};
  endfunction

endpackage

// File: rtl/spif_pin_sync.sv
// Pin conditioning for the SPI-flash responder.
//   clk, rst_n : system clock, synchronous active-low reset
//   sclk, cs_n : asynchronous SPI clock / chip select pins
//   mosi_pin   : asynchronous qdi[0]
//   cs_active  : synchronized chip select (1 = selected)
//   sck_rise   : one-cycle pulse per sclk rising edge
//   sck_fall   : one-cycle pulse per sclk falling edge
//   mosi       : synchronized MOSI, aligned with the edge pulses
module spif_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi_pin,
  output logic cs_active,
  output logic sck_rise,
  output logic sck_fall,
  output logic mosi
);

  logic [2:0] sck_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;
  logic       cs_active_q, rise_q, fall_q, mosi_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q       <= '0;
      // cs syncs reset to "selected" so a cs_n held low across reset never
      // looks like a fresh falling edge.
      cs_q        <= '0;
      mosi_q      <= '0;
      cs_active_q <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      mosi_out_q  <= 1'b0;
    end else begin
      sck_q       <= {sck_q[1:0], sclk};
      cs_q        <= {cs_q[0], cs_n};
      mosi_q      <= {mosi_q[0], mosi_pin};
      rise_q      <= sck_q[1] & ~sck_q[2];
      fall_q      <= ~sck_q[1] & sck_q[2];
      cs_active_q <= ~cs_q[1];
      mosi_out_q  <= mosi_q[1];
    end
  end

  assign cs_active = cs_active_q;
  assign sck_rise  = rise_q;
  assign sck_fall  = fall_q;
  assign mosi      = mosi_out_q;

endmodule

// File: rtl/spif_responder.sv
// SPI-flash target emulator backed by a synchronous byte memory.
//   clk, rst_n        : system clock (>= 8x sclk), synchronous active-low reset
//   sclk, cs_n, qdi   : SPI mode-0 bus from the initiator (qdi[0] = MOSI)
//   qdo, oe           : data and per-line enables back to the initiator
//   mem_addr/rd/rdata : byte read port, rdata valid 1 clk after mem_rd
//   mem_wr/wdata      : byte write port
// Supports 03h/0Bh/6Bh reads, 9Fh ID, 05h status, 06h/04h WEL, 02h program.
module spif_responder #(
  parameter int unsigned AW       = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic [3:0]    qdi,
  output logic [3:0]    qdo,
  output logic [3:0]    oe,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata
);
  import spif_responder_pkg::*;

  logic cs_active, sck_rise, sck_fall, mosi;
  logic unused_qdi;
  assign unused_qdi = ^qdi[3:1];

  spif_pin_sync u_pin_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi_pin (qdi[0]),
    .cs_active(cs_active),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .mosi     (mosi)
  );

  state_e        state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   sr_q, sr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    page_off_q, page_off_d;
  logic          wel_q, wel_d, wrote_q, wrote_d, quad_q, quad_d;
  logic [2:0]    out_cnt_q, out_cnt_d;
  logic [7:0]    out_sr_q, out_sr_d, nxt_q, nxt_d;
  logic [1:0]    id_idx_q, id_idx_d;
  logic          rd_pend_q, rd_pend_d, cs_prev_q, cs_prev_d;
  logic [3:0]    qdo_q, qdo_d, oe_q, oe_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;

  logic [23:0] sr_shift;
  logic [7:0]  ld_byte;
  logic        byte_end;

  assign sr_shift = {sr_q[22:0], mosi};

  // Byte to present at the start of each output byte.
  always_comb begin
    ld_byte = nxt_q;
    if (state_q == StIdOut) begin
      case (id_idx_q)
        2'd0:    ld_byte = JEDEC_ID[23:16];
        2'd1:    ld_byte = JEDEC_ID[15:8];
        default: ld_byte = JEDEC_ID[7:0];
      endcase
    end else if (state_q == StStatOut) begin
      ld_byte = {6'b0, wel_q, 1'b0};
    end
  end

  assign byte_end = quad_q ? (out_cnt_q == 3'd1) : (out_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    page_off_d  = page_off_q;
    wel_d       = wel_q;
    wrote_d     = wrote_q;
    quad_d      = quad_q;
    out_cnt_d   = out_cnt_q;
    out_sr_d    = out_sr_q;
    id_idx_d    = id_idx_q;
    nxt_d       = rd_pend_q ? mem_rdata : nxt_q;
    rd_pend_d   = mem_rd_q;
    cs_prev_d   = cs_active;
    qdo_d       = qdo_q;
    oe_d        = oe_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    if (!cs_active) begin
      // Deselect wins over any coincident sclk edge.
      state_d = StIdle;
      oe_d    = '0;
      qdo_d   = '0;
      if (wrote_q) wel_d = 1'b0;
      wrote_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cs_prev_q) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            sr_d      = sr_shift;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              cmd_d     = sr_shift[7:0];
              quad_d    = (sr_shift[7:0] == CMD_QREAD);
              out_cnt_d = '0;
              id_idx_d  = '0;
              case (sr_shift[7:0])
                CMD_READ, CMD_FREAD, CMD_QREAD, CMD_PP: state_d = StAddr;
                CMD_RDID: state_d = StIdOut;
                CMD_RDSR: state_d = StStatOut;
                CMD_WREN: begin wel_d = 1'b1; state_d = StIgnore; end
                CMD_WRDI: begin wel_d = 1'b0; state_d = StIgnore; end
                default:  state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            sr_d      = sr_shift;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d  = '0;
              addr_d     = sr_shift[AW-1:0];
              page_off_d = sr_shift[7:0];
              if (cmd_q == CMD_PP) begin
                state_d = StDataIn;
              end else if (cmd_q == CMD_READ) begin
                state_d    = StDataOut;
                mem_rd_d   = 1'b1;
                mem_addr_d = sr_shift[AW-1:0];
              end else begin
                state_d = StDummy;
              end
            end
          end
        end
        StDummy: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(DUMMY_BITS - 1)) begin
              bit_cnt_d  = '0;
              state_d    = StDataOut;
              mem_rd_d   = 1'b1;
              mem_addr_d = addr_q;
            end
          end
        end
        StDataOut, StIdOut, StStatOut: begin
          if (sck_fall) begin
            if (out_cnt_q == 3'd0) begin
              oe_d     = quad_q ? 4'hF : 4'b0010;
              qdo_d    = out_lines(quad_q, ld_byte);
              out_sr_d = quad_q ? {ld_byte[3:0], 4'h0} : {ld_byte[6:0], 1'b0};
              // Prefetch the following byte while this one shifts out.
              if (state_q == StDataOut) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = mem_addr_q + AW'(1);
              end
              if (state_q == StIdOut && id_idx_q != 2'd2) id_idx_d = id_idx_q + 2'd1;
            end else begin
              qdo_d    = out_lines(quad_q, out_sr_q);
              out_sr_d = quad_q ? {out_sr_q[3:0], 4'h0} : {out_sr_q[6:0], 1'b0};
            end
            out_cnt_d = byte_end ? 3'd0 : out_cnt_q + 3'd1;
          end
        end
        StDataIn: begin
          if (sck_rise) begin
            sr_d      = sr_shift;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (wel_q) begin
                mem_wr_d    = 1'b1;
                mem_wdata_d = sr_shift[7:0];
                mem_addr_d  = {addr_q[AW-1:8], page_off_q};
                page_off_d  = page_off_q + 8'd1;
                wrote_d     = 1'b1;
              end
            end
          end
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      page_off_q  <= '0;
      wel_q       <= 1'b0;
      wrote_q     <= 1'b0;
      quad_q      <= 1'b0;
      out_cnt_q   <= '0;
      out_sr_q    <= '0;
      id_idx_q    <= '0;
      nxt_q       <= '0;
      rd_pend_q   <= 1'b0;
      cs_prev_q   <= 1'b1;
      qdo_q       <= '0;
      oe_q        <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      page_off_q  <= page_off_d;
      wel_q       <= wel_d;
      wrote_q     <= wrote_d;
      quad_q      <= quad_d;
      out_cnt_q   <= out_cnt_d;
      out_sr_q    <= out_sr_d;
      id_idx_q    <= id_idx_d;
      nxt_q       <= nxt_d;
      rd_pend_q   <= rd_pend_d;
      cs_prev_q   <= cs_prev_d;
      qdo_q       <= qdo_d;
      oe_q        <= oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign qdo       = qdo_q;
  assign oe        = oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_spif_responder.sv
// Bench for spif_responder: drives SPI mode-0 frames and checks the replies
// against expectations computed from the flash command rules.
module tb_spif_responder;

  localparam int HALF = 6;  // clk cycles per sclk phase
  localparam logic [23:0] ID = 24'hEF4018;

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs_n;
  logic [3:0]  qdi, qdo, oe;
  logic [23:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [logic [23:0]];
  logic [31:0] wr_log [$];

  always #5 clk = ~clk;

  spif_responder #(.AW(24), .JEDEC_ID(ID)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .qdi      (qdi),
    .qdo      (qdo),
    .oe       (oe),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata)
  );

  // Synchronous byte memory: data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    if (mem_wr) begin
      mem[mem_addr] = mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit: MOSI set while low, slave output sampled just before rise.
  task automatic xfer(input logic mo, output logic [3:0] q, output logic [3:0] o);
    qdi[0] = mo;
    wait_clk(HALF);
    q = qdo;
    o = oe;
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [3:0] oe_or);
    logic [3:0] q, o;
    oe_or = '0;
    for (int i = 7; i >= 0; i--) begin
      xfer(b[i], q, o);
      oe_or |= o;
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] o;
    send_byte(a[23:16], o);
    send_byte(a[15:8], o);
    send_byte(a[7:0], o);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic [3:0] oa, output logic [3:0] oo);
    logic [3:0] q, o;
    b = '0; oa = 4'hF; oo = 4'h0;
    for (int i = 0; i < 8; i++) begin
      xfer(1'($urandom), q, o);
      b = {b[6:0], q[1]};
      oa &= o; oo |= o;
    end
  endtask

  task automatic recv_quad(output logic [7:0] b, output logic [3:0] oa, output logic [3:0] oo);
    logic [3:0] q1, q2, o1, o2;
    xfer(1'($urandom), q1, o1);
    xfer(1'($urandom), q2, o2);
    b = {q1, q2}; oa = o1 & o2; oo = o1 | o2;
  endtask

  task automatic simple_cmd(input logic [7:0] op);
    logic [3:0] o;
    cs_low(); send_byte(op, o); cs_high();
  endtask

  task automatic do_rdsr(output logic [7:0] s);
    logic [3:0] o, oa, oo;
    cs_low(); send_byte(8'h05, o); recv_byte(s, oa, oo); cs_high();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; qdi = 4'h0;
    wait_clk(5);
    checks++; if (qdo !== 4'h0) begin failures++; $display("FAIL reset_qdo: got %h expected 0", qdo); end
    checks++; if (oe !== 4'h0) begin failures++; $display("FAIL reset_oe: got %h expected 0", oe); end
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      failures++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0 0", mem_rd, mem_wr); end
    checks++; if (mem_addr !== 24'h0 || mem_wdata !== 8'h0) begin
      failures++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); end
    rst_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_status(input logic [7:0] exp_s, input string tag);
    logic [7:0] s;
    do_rdsr(s);
    checks++; if (s !== exp_s) begin failures++; $display("FAIL %s: got %h expected %h", tag, s, exp_s); end
  endtask

  task automatic test_rdid();
    logic [7:0] b, e;
    logic [3:0] o, oa, oo;
    cs_low(); send_byte(8'h9F, o);
    for (int i = 0; i < 5; i++) begin
      e = (i < 3) ? 8'(ID >> (8 * (2 - i))) : ID[7:0];
      recv_byte(b, oa, oo);
      checks++; if (b !== e) begin failures++; $display("FAIL rdid_byte%0d: got %h expected %h", i, b, e); end
      checks++; if (oa !== 4'b0010 || oo !== 4'b0010) begin
        failures++; $display("FAIL rdid_oe%0d: got and=%h or=%h expected 2", i, oa, oo); end
    end
    cs_high();
  endtask

  task automatic test_read_cmd(input logic [7:0] op, input logic [23:0] a, input int n, input string tag);
    logic [7:0]  expd [$];
    logic [7:0]  b;
    logic [3:0]  o, oa, oo, eoe;
    logic [23:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 24'(i);
      if (!mem.exists(ai)) mem[ai] = 8'($urandom);
      expd.push_back(mem[ai]);
    end
    eoe = (op == 8'h6B) ? 4'hF : 4'b0010;
    cs_low(); send_byte(op, o); send_addr(a);
    if (op != 8'h03) send_byte(8'($urandom), o);
    for (int i = 0; i < n; i++) begin
      if (op == 8'h6B) recv_quad(b, oa, oo); else recv_byte(b, oa, oo);
      checks++; if (b !== expd[i]) begin
        failures++; $display("FAIL %s_byte%0d @%h: got %h expected %h", tag, i, a + 24'(i), b, expd[i]); end
      checks++; if (oa !== eoe || oo !== eoe) begin
        failures++; $display("FAIL %s_oe%0d: got and=%h or=%h expected %h", tag, i, oa, oo, eoe); end
    end
    cs_high();
  endtask

  task automatic test_program(input logic wren, input logic [23:0] a, input int n, input string tag);
    logic [31:0] expw [$];
    logic [7:0]  d, off;
    logic [3:0]  o;
    if (wren) begin
      simple_cmd(8'h06);
      test_status(8'h02, {tag, "_wel_set"});
    end
    wr_log.delete();
    cs_low(); send_byte(8'h02, o); send_addr(a);
    for (int i = 0; i < n; i++) begin
      d = (i == 0 && !wren) ? 8'h11 : 8'($urandom);
      off = a[7:0] + 8'(i);
      if (wren) expw.push_back({a[23:8], off, d});
      send_byte(d, o);
    end
    cs_high();
    checks++; if (wr_log.size() != expw.size()) begin
      failures++; $display("FAIL %s_count: got %0d expected %0d", tag, wr_log.size(), expw.size());
    end else begin
      for (int i = 0; i < expw.size(); i++) begin
        checks++; if (wr_log[i] !== expw[i]) begin
          failures++; $display("FAIL %s_wr%0d: got %h expected %h", tag, i, wr_log[i], expw[i]); end
      end
    end
    test_status(8'h00, {tag, "_rdsr"});
  endtask

  task automatic test_abort();
    logic [3:0] o, q;
    simple_cmd(8'h06);
    wr_log.delete();
    cs_low(); send_byte(8'h02, o); send_addr(24'h000340);
    for (int i = 0; i < 5; i++) xfer(1'($urandom), q, o);
    cs_high();
    checks++; if (wr_log.size() != 0) begin
      failures++; $display("FAIL abort_nowrite: got %0d writes expected 0", wr_log.size()); end
    test_status(8'h02, "abort_wel_kept");
    simple_cmd(8'h04);
    test_status(8'h00, "wrdi_clears");
  endtask

  task automatic test_bad_opcode();
    logic [7:0] ops [5];
    logic [7:0] r;
    logic [3:0] o, oo;
    ops[0] = 8'h77; ops[1] = 8'h00; ops[2] = 8'hFF; ops[3] = 8'h3B;
    do r = 8'($urandom);
    while (r inside {8'h03, 8'h0B, 8'h6B, 8'h9F, 8'h05, 8'h06, 8'h04, 8'h02});
    ops[4] = r;
    wr_log.delete();
    for (int k = 0; k < 5; k++) begin
      cs_low();
      send_byte(ops[k], oo);
      for (int i = 0; i < 3; i++) begin send_byte(8'($urandom), o); oo |= o; end
      cs_high();
      checks++; if (oo !== 4'h0) begin
        failures++; $display("FAIL badop_%h_oe: got %h expected 0", ops[k], oo); end
    end
    checks++; if (wr_log.size() != 0) begin
      failures++; $display("FAIL badop_nowrite: got %0d expected 0", wr_log.size()); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] b;
    logic [3:0] o, oa, oo, q;
    mem[24'h000500] = 8'hFF;
    cs_low(); send_byte(8'h03, o); send_addr(24'h000500);
    recv_byte(b, oa, oo);
    xfer(1'b0, q, o);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (oe !== 4'h0 || qdo !== 4'h0) begin
      failures++; $display("FAIL midreset_outputs: got oe=%h qdo=%h expected 0 0", oe, qdo); end
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    // cs_n is still low: no new frame may start.
    send_byte(8'h9F, oo);
    for (int i = 0; i < 2; i++) begin send_byte(8'h00, o); oo |= o; end
    checks++; if (oo !== 4'h0) begin
      failures++; $display("FAIL held_cs_idle_oe: got %h expected 0", oo); end
    cs_high();
    test_rdid();
  endtask

  initial begin
    test_reset();
    test_status(8'h00, "rdsr_after_reset");
    test_rdid();
    mem[24'h000010] = 8'hA5; mem[24'h000011] = 8'h5A; mem[24'h000012] = 8'hC3;
    test_read_cmd(8'h03, 24'h000010, 3, "read_10");
    mem[24'hFFFFFF] = 8'h96; mem[24'h000000] = 8'h69;
    test_read_cmd(8'h03, 24'hFFFFFE, 4, "read_wrap");
    test_read_cmd(8'h03, 24'($urandom), 3, "read_rand");
    test_read_cmd(8'h0B, 24'($urandom), 3, "fread_rand");
    mem[24'h000100] = 8'h3C;
    test_read_cmd(8'h6B, 24'h000100, 1, "qread_100");
    test_read_cmd(8'h6B, 24'($urandom), 4, "qread_rand");
    test_program(1'b0, 24'h000200, 1, "pp_nowren");
    test_program(1'b1, 24'h0002FE, 3, "pp_wrap");
    test_program(1'b1, {16'($urandom), 8'($urandom)}, int'($urandom_range(1, 5)), "pp_rand");
    test_read_cmd(8'h03, 24'h0002FE, 2, "readback");
    test_abort();
    test_bad_opcode();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spif_responder.md
# spif_responder

Synthesizable SPI-flash target that answers the MCU's flash port (sclk, cs_n, qdo/oe) on boards and benches that have no real flash chip, backed by an external synchronous byte memory. It oversamples the SPI pins with the system clock and decodes a subset of the serial-flash command set: read, fast read, quad-output read, JEDEC ID, status, write enable/disable and page program. The block sits at the far end of the MCU's QSPI bus, in place of the flash device.

## Interface
Parameters:
- AW, 24: byte address width; addresses wrap modulo 2^AW.
- JEDEC_ID, 24'hEF4018: three ID bytes returned by 9Fh, MSB first.

Ports:
- clk  in  1  system clock; must be ≥ 8× sclk frequency.
- rst_n  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from the initiator, mode 0; asynchronous.
- cs_n  in  1  chip select, active low; asynchronous.
- qdi  in  4  data from the initiator; only qdi[0] (MOSI) is used.
- qdo  out  4  data to the initiator.
- oe  out  4  per-line output enable toward the initiator.
- mem_addr  out  AW  byte address.
- mem_rd  out  1  read strobe, one cycle wide.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_rd.
- mem_wr  out  1  write strobe, one cycle wide.
- mem_wdata  out  8  write data, qualified by mem_wr.

## Operation
- sclk, cs_n and qdi[0] each pass through a 2-flop synchronizer. A third flop on sclk provides edge detection.
  - Rising edge: sample MOSI.
  - Falling edge: advance the output shifter.
- cs_n high (synchronized) forces IDLE. A partial byte is discarded and oe is set to 0.
- States:
  - IDLE: on cs_n falling, go to CMD and clear the bit counter.
  - CMD: 8 bits, MSB first, then dispatch on the opcode:
    - 03h: ADDR then DATA_OUT, single line.
    - 0Bh: ADDR, DUMMY (8 clocks), then DATA_OUT, single line.
    - 6Bh: ADDR, DUMMY (8 clocks), then DATA_OUT, quad.
    - 9Fh: ID_OUT.
    - 05h: STAT_OUT.
    - 06h: set WEL, then IGNORE.
    - 04h: clear WEL, then IGNORE.
    - 02h: ADDR then DATA_IN.
    - Any other opcode: IGNORE.
  - ADDR: 24 bits, MSB first. The low AW bits are kept.
  - DATA_OUT (single line):
    - qdo[1] carries the byte MSB first; oe = 4'b0010.
    - The first bit appears on the first falling edge after the last address/dummy bit.
  - DATA_OUT (quad):
    - qdo = nibble, high nibble first, 2 sclk per byte; oe = 4'hF.
  - Read address handling: increments after each byte and wraps at 2^AW. The next byte is prefetched (mem_rd) when the current byte's first bit is driven.
  - ID_OUT: JEDEC_ID bytes in order. The third byte repeats while cs_n stays low.
  - STAT_OUT: byte {6'b0, WEL, WIP=0}, repeated while cs_n stays low.
  - DATA_IN (only when WEL=1):
    - Each completed byte issues mem_wr at {addr[AW-1:8], page_offset}.
    - page_offset increments modulo 256, so writes wrap within the page.
    - With WEL=0 the bytes are discarded.
    - On cs_n rising after ≥1 byte was written, WEL clears.
  - IGNORE: oe = 0 until cs_n rises.
- WEL resets to 0. No other persistent state exists.

## Timing
- Reset values:
  - qdo = 0, oe = 0.
  - mem_rd = 0, mem_wr = 0.
  - mem_addr = 0, mem_wdata = 0.
  - state IDLE, WEL = 0.
- Pin-to-action latency is 3 clk from an sclk/cs_n pin edge to the internal edge pulse. Outputs update 1 clk later (registered).
- The initiator's sclk high and low phases must each be ≥ 4 clk. This keeps qdo stable before the next sampling rising edge.
- mem_rd is asserted ≥ 2 clk before the byte's first bit is needed. mem_rdata is captured into the shifter on the cycle after mem_rd.
- mem_wr fires 1 clk after the rising edge that completes the 8th bit.
- Simultaneous cs_n rise and sclk edge: cs_n wins and no bit is taken.
- rst_n low mid-transfer: everything returns to reset values on the next clk, regardless of cs_n.
- cs_n low held across reset: the block stays in IDLE until cs_n goes high and then low again.

## Structure
- A shared package holds:
  - opcode constants: CMD_READ, CMD_FREAD, CMD_QREAD, CMD_RDID, CMD_RDSR, CMD_WREN, CMD_WRDI, CMD_PP;
  - the state enum;
  - DUMMY_BITS = 8.
- One sub-module, spif_pin_sync: synchronizers and edge detect. It outputs cs_active, sck_rise, sck_fall and mosi.
- The top level holds the FSM, shifters, address counter and WEL.

## Test plan
- RDID: cs_n low, 9Fh, 24 sclk → bytes EFh, 40h, 18h on qdo[1] with oe = 0010.
- READ: 03h addr 000010h with mem[10h..12h] = A5h, 5Ah, C3h → A5 5A C3; a read at address FFFFFFh wraps to 000000h.
- Quad read: 6Bh addr 000100h, 8 dummy clocks → mem[100h] = 3Ch appears as nibble 3h then Ch with oe = Fh.
- Program without WREN:
  - 02h addr 000200h with data 11h → no mem_wr;
  - a following RDSR returns 00h.
- Program with WREN:
  - 06h, then 02h at 0002FEh with 3 bytes → writes at 2FEh, 2FFh, 200h;
  - RDSR afterward returns 00h.
- Abort and bad opcode:
  - cs_n rises after 5 bits of a program byte → no mem_wr;
  - opcode 77h → oe stays 0 for the whole frame;
  - rst_n mid-read → oe = 0 on the next clk.
